// File: rtl/multicycle_ctrl_fsm_if.sv
// Unified instruction/data memory port between the multicycle control unit and memory.
// Latency: none, plain wires; an access completes in the cycle mem_ready is high with mem_req.
// Backpressure: memory stalls the controller by holding mem_ready low while mem_req is high.
// Ports: mem_req (access requested), AdrSrc (0 PC, 1 ALUOut address), MemWrite (write strobe),
//        mem_ready (memory finishes the current access this cycle).
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic AdrSrc;
  logic MemWrite;
  logic mem_ready;

  modport master (output mem_req, output AdrSrc, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input AdrSrc, input MemWrite, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control unit: steps FETCH/DECODE/EXECUTE/MEM/WB per opcode, emits datapath strobes.
// Latency: 3 (beq) to 5 (lw) cycles per instruction with zero memory wait, plus one cycle per wait.
// Backpressure: memory states hold while mem_ready is low; MEM_TIMEOUT waits without ready traps.
// Ports: clk/reset (sync, active-high); mem (memory handshake, master side); opcode, zero (ALU flag);
//        IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc (datapath controls);
//        illegal, mem_fault (sticky traps); retire (last cycle of an instruction); instret (count).
module multicycle_ctrl_fsm #(
  parameter bit ENABLE_LUI  = 1'b1,
  parameter bit ENABLE_JALR = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master mem,
  input  logic [6:0]            opcode,
  input  logic                  zero,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ALUOp,
  output logic [1:0]            ResultSrc,
  output logic [2:0]            ImmSrc,
  output logic                  illegal,
  output logic                  mem_fault,
  output logic                  retire,
  output logic [CNT_W-1:0]      instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JALR_EX  = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  // Wait counter only needs to reach MEM_TIMEOUT-1 before the trap fires.
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WW'(MEM_TIMEOUT - 1) : '0;

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  logic             fault_q;
  logic             mem_state;
  logic             timeout;

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);

  // A ready in the last allowed cycle completes the access instead of trapping.
  assign timeout = mem_state && !mem.mem_ready && (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (mem.mem_ready)  state_nxt = S_DECODE;
        else if (timeout)   state_nxt = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXEC_R;
          OP_I:         state_nxt = S_EXEC_I;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          OP_JALR:      state_nxt = ENABLE_JALR ? S_JALR_EX : S_TRAP;
          OP_LUI:       state_nxt = ENABLE_LUI ? S_LUI : S_TRAP;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem.mem_ready)  state_nxt = S_MEMWB;
        else if (timeout)   state_nxt = S_TRAP;
      end
      S_MEMWRITE: begin
        if (mem.mem_ready)  state_nxt = S_FETCH;
        else if (timeout)   state_nxt = S_TRAP;
      end
      S_MEMWB, S_ALUWB, S_BEQ:   state_nxt = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_LUI: state_nxt = S_ALUWB;
      S_JALR_EX:                 state_nxt = S_JAL;
      // JAL doubles as the link step of JALR: PC <= ALUOut, then rd <= OldPC+4.
      S_JAL:                     state_nxt = S_ALUWB;
      S_TRAP:                    state_nxt = S_TRAP;
      default:                   state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem.mem_req  = 1'b0;
    mem.AdrSrc   = 1'b0;
    mem.MemWrite = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    ResultSrc    = 2'b00;
    retire       = 1'b0;
    case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        IRWrite     = mem.mem_ready;
        PCWrite     = mem.mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR, S_JALR_EX: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem.mem_req = 1'b1;
        mem.AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        mem.mem_req  = 1'b1;
        mem.AdrSrc   = 1'b1;
        mem.MemWrite = 1'b1;
        retire       = mem.mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_LUI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = zero;
        retire  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides the state so an aborted instruction issues nothing.
    if (reset) begin
      mem.mem_req  = 1'b0;
      mem.AdrSrc   = 1'b0;
      mem.MemWrite = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      ResultSrc    = 2'b00;
      retire       = 1'b0;
    end
  end

  always_comb begin
    ImmSrc = 3'b000;
    if (!reset) begin
      case (opcode)
        OP_SW:   ImmSrc = 3'b001;
        OP_BEQ:  ImmSrc = 3'b010;
        OP_JAL:  ImmSrc = 3'b011;
        OP_LUI:  ImmSrc = ENABLE_LUI ? 3'b100 : 3'b000;
        default: ImmSrc = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      // Any state change restarts the count, which covers entry into every memory state.
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (mem_state && !mem.mem_ready)
        wait_cnt <= wait_cnt + WW'(1);
      if ((state == S_DECODE) && (state_nxt == S_TRAP))
        illegal_q <= 1'b1;
      if (timeout)
        fault_q <= 1'b1;
      if (retire)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign illegal   = illegal_q & ~reset;
  assign mem_fault = fault_q & ~reset;
  assign instret   = reset ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: a default-parameter instance (a) and a reduced one (b:
// no LUI/JALR, MEM_TIMEOUT=4, CNT_W=4). Expected per-cycle strobes come from instruction phase lists.
module tb_multicycle_ctrl_fsm;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct packed {
    logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, retire;
    logic [1:0] a, b, op, rs;
  } strb_t;

  // Field order: {mem_req,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,retire}, {A,B,ALUOp,ResultSrc}
  localparam strb_t P_F   = {7'b1000000, 8'b00_10_00_10};
  localparam strb_t P_FD  = {7'b1001100, 8'b00_10_00_10};
  localparam strb_t P_D   = {7'b0000000, 8'b01_01_00_00};
  localparam strb_t P_MA  = {7'b0000000, 8'b10_01_00_00};
  localparam strb_t P_MR  = {7'b1100000, 8'b00_00_00_00};
  localparam strb_t P_MWB = {7'b0000011, 8'b00_00_00_01};
  localparam strb_t P_MW  = {7'b1110000, 8'b00_00_00_00};
  localparam strb_t P_MWD = {7'b1110001, 8'b00_00_00_00};
  localparam strb_t P_ER  = {7'b0000000, 8'b10_00_10_00};
  localparam strb_t P_EI  = {7'b0000000, 8'b10_01_10_00};
  localparam strb_t P_LU  = {7'b0000000, 8'b00_01_11_00};
  localparam strb_t P_AWB = {7'b0000011, 8'b00_00_00_00};
  localparam strb_t P_BQ0 = {7'b0000001, 8'b10_00_01_00};
  localparam strb_t P_BQ1 = {7'b0000101, 8'b10_00_01_00};
  localparam strb_t P_JX  = {7'b0000000, 8'b10_01_00_00};
  localparam strb_t P_JL  = {7'b0000100, 8'b01_10_00_00};
  localparam strb_t P_TR  = {7'b0000000, 8'b00_00_00_00};

  typedef struct {
    logic [6:0] op;
    logic       z;
    int         wf, wm;
    int         ret_at, npc, nrw, nmw;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [6:0] opcode;
  bit         sel;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if ifa ();
  multicycle_ctrl_fsm_if ifb ();
  assign ifa.mem_ready = mem_ready;
  assign ifb.mem_ready = mem_ready;

  logic        a_irw, a_pcw, a_rw, a_ill, a_mf, a_ret;
  logic [1:0]  a_sa, a_sb, a_op, a_rs;
  logic [2:0]  a_imm;
  logic [31:0] a_cnt;
  logic        b_irw, b_pcw, b_rw, b_ill, b_mf, b_ret;
  logic [1:0]  b_sa, b_sb, b_op, b_rs;
  logic [2:0]  b_imm;
  logic [3:0]  b_cnt;

  multicycle_ctrl_fsm dut_a (
    .clk(clk), .reset(reset), .mem(ifa), .opcode(opcode), .zero(zero),
    .IRWrite(a_irw), .PCWrite(a_pcw), .RegWrite(a_rw), .ALUSrcA(a_sa), .ALUSrcB(a_sb),
    .ALUOp(a_op), .ResultSrc(a_rs), .ImmSrc(a_imm), .illegal(a_ill), .mem_fault(a_mf),
    .retire(a_ret), .instret(a_cnt)
  );

  multicycle_ctrl_fsm #(.ENABLE_LUI(1'b0), .ENABLE_JALR(1'b0), .MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .mem(ifb), .opcode(opcode), .zero(zero),
    .IRWrite(b_irw), .PCWrite(b_pcw), .RegWrite(b_rw), .ALUSrcA(b_sa), .ALUSrcB(b_sb),
    .ALUOp(b_op), .ResultSrc(b_rs), .ImmSrc(b_imm), .illegal(b_ill), .mem_fault(b_mf),
    .retire(b_ret), .instret(b_cnt)
  );

  strb_t       sa, sb, o_s;
  logic [2:0]  o_imm;
  logic        o_ill, o_mf;
  logic [31:0] o_cnt;
  assign sa    = {ifa.mem_req, ifa.AdrSrc, ifa.MemWrite, a_irw, a_pcw, a_rw, a_ret, a_sa, a_sb, a_op, a_rs};
  assign sb    = {ifb.mem_req, ifb.AdrSrc, ifb.MemWrite, b_irw, b_pcw, b_rw, b_ret, b_sa, b_sb, b_op, b_rs};
  assign o_s   = sel ? sb : sa;
  assign o_imm = sel ? b_imm : a_imm;
  assign o_ill = sel ? b_ill : a_ill;
  assign o_mf  = sel ? b_mf : a_mf;
  assign o_cnt = sel ? {28'd0, b_cnt} : a_cnt;

  int          n_cmp, n_err;
  logic [31:0] inst_m;
  logic        ill_m, mf_m;
  int          cyc_g, ret_g, npc_g, nrw_g, nmw_g;
  vec_t        tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", nm, act, exp, $time, sel);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 3'b001;
      OP_BEQ:  return 3'b010;
      OP_JAL:  return 3'b011;
      OP_LUI:  return sel ? 3'b000 : 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit legal_a(input logic [6:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_JALR, OP_LUI};
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare just after it.
  task automatic cyc(input logic [6:0] op, input logic z, input logic rdy, input strb_t exp,
                     input bit ci, input string nm);
    @(negedge clk);
    reset = 1'b0; opcode = op; zero = z; mem_ready = rdy;
    #1;
    chk(nm, 32'(o_s), 32'(exp));
    if (ci) chk({nm, "_imm"}, 32'(o_imm), 32'(imm_of(op)));
    chk({nm, "_flags"}, {30'd0, o_ill, o_mf}, {30'd0, ill_m, mf_m});
    chk({nm, "_instret"}, o_cnt, sel ? (inst_m & 32'hF) : inst_m);
    cyc_g++;
    if (o_s.PCWrite)  npc_g++;
    if (o_s.RegWrite) nrw_g++;
    if (o_s.MemWrite) nmw_g++;
    if (o_s.retire && ret_g == 0) ret_g = cyc_g;
    if (exp.retire) inst_m++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; opcode = OP_SW; zero = 1'b1; mem_ready = 1'b1;
      #1;
      chk("rst_strobes", 32'(o_s), 32'd0);
      chk("rst_imm", 32'(o_imm), 32'd0);
      chk("rst_flags", {30'd0, o_ill, o_mf}, 32'd0);
      chk("rst_instret", o_cnt, 32'd0);
    end
    inst_m = '0; ill_m = 1'b0; mf_m = 1'b0;
  endtask

  // Whole instruction: fetch with wf stalls, decode, then the opcode's phases (wm memory stalls).
  task automatic run_instr(input logic [6:0] op, input logic z, input int wf, input int wm);
    cyc_g = 0; ret_g = 0; npc_g = 0; nrw_g = 0; nmw_g = 0;
    for (int i = 0; i < wf; i++) cyc(op, rb(), 1'b0, P_F, 1'b1, "fetch_wait");
    cyc(op, rb(), 1'b1, P_FD, 1'b1, "fetch");
    cyc(op, rb(), rb(), P_D, 1'b1, "decode");
    case (op)
      OP_LW: begin
        cyc(op, rb(), rb(), P_MA, 1'b1, "memadr");
        for (int i = 0; i < wm; i++) cyc(op, rb(), 1'b0, P_MR, 1'b1, "memread_wait");
        cyc(op, rb(), 1'b1, P_MR, 1'b1, "memread");
        cyc(op, rb(), rb(), P_MWB, 1'b1, "memwb");
      end
      OP_SW: begin
        cyc(op, rb(), rb(), P_MA, 1'b1, "memadr");
        for (int i = 0; i < wm; i++) cyc(op, rb(), 1'b0, P_MW, 1'b1, "memwrite_wait");
        cyc(op, rb(), 1'b1, P_MWD, 1'b1, "memwrite");
      end
      OP_R: begin
        cyc(op, rb(), rb(), P_ER, 1'b1, "exec_r");
        cyc(op, rb(), rb(), P_AWB, 1'b1, "aluwb");
      end
      OP_I: begin
        cyc(op, rb(), rb(), P_EI, 1'b1, "exec_i");
        cyc(op, rb(), rb(), P_AWB, 1'b1, "aluwb");
      end
      OP_LUI: begin
        cyc(op, rb(), rb(), P_LU, 1'b1, "lui");
        cyc(op, rb(), rb(), P_AWB, 1'b1, "aluwb");
      end
      OP_BEQ: cyc(op, z, rb(), z ? P_BQ1 : P_BQ0, 1'b1, "beq");
      OP_JAL: begin
        cyc(op, rb(), rb(), P_JL, 1'b1, "jal");
        cyc(op, rb(), rb(), P_AWB, 1'b1, "aluwb");
      end
      OP_JALR: begin
        cyc(op, rb(), rb(), P_JX, 1'b1, "jalr_ex");
        cyc(op, rb(), rb(), P_JL, 1'b1, "jal");
        cyc(op, rb(), rb(), P_AWB, 1'b1, "aluwb");
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [6:0] op;
    logic [6:0] ops[8];
    n_cmp = 0; n_err = 0; sel = 1'b0;
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    inst_m = '0; ill_m = 1'b0; mf_m = 1'b0;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_JALR, OP_LUI};

    //          op       z     wf wm  retire@ PCW RegW MemW
    tbl[0] = '{OP_LW,   1'b0, 0, 0,  5,      1,  1,   0};
    tbl[1] = '{OP_SW,   1'b0, 0, 3,  7,      1,  0,   4};
    tbl[2] = '{OP_BEQ,  1'b1, 0, 0,  3,      2,  0,   0};
    tbl[3] = '{OP_BEQ,  1'b0, 0, 0,  3,      1,  0,   0};
    tbl[4] = '{OP_R,    1'b0, 1, 0,  5,      1,  1,   0};
    tbl[5] = '{OP_I,    1'b0, 0, 0,  4,      1,  1,   0};
    tbl[6] = '{OP_JAL,  1'b0, 0, 0,  4,      2,  1,   0};
    tbl[7] = '{OP_JALR, 1'b0, 2, 0,  7,      2,  1,   0};
    tbl[8] = '{OP_LUI,  1'b0, 0, 0,  4,      1,  1,   0};
    tbl[9] = '{OP_LW,   1'b0, 1, 2,  8,      1,  1,   0};

    do_reset(2);
    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].z, tbl[i].wf, tbl[i].wm);
      chk("tbl_retire_cycle", 32'(ret_g), 32'(tbl[i].ret_at));
      chk("tbl_pcwrite_cycles", 32'(npc_g), 32'(tbl[i].npc));
      chk("tbl_regwrite_cycles", 32'(nrw_g), 32'(tbl[i].nrw));
      chk("tbl_memwrite_cycles", 32'(nmw_g), 32'(tbl[i].nmw));
    end

    // Random instruction stream on the full-featured instance.
    repeat (40) begin
      op = ops[$urandom_range(0, 7)];
      run_instr(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Random undefined opcode traps after decode.
    do op = 7'($urandom); while (legal_a(op));
    cyc(op, rb(), 1'b1, P_FD, 1'b1, "ill_fetch");
    cyc(op, rb(), rb(), P_D, 1'b1, "ill_decode");
    ill_m = 1'b1;
    repeat (3) cyc(op, rb(), rb(), P_TR, 1'b0, "ill_trap");

    // Reset while a load waits in MEMREAD: nothing issued, restart at FETCH.
    do_reset(1);
    cyc(OP_LW, 1'b0, 1'b1, P_FD, 1'b1, "ab_fetch");
    cyc(OP_LW, 1'b0, 1'b0, P_D, 1'b1, "ab_decode");
    cyc(OP_LW, 1'b0, 1'b0, P_MA, 1'b1, "ab_memadr");
    repeat (2) cyc(OP_LW, 1'b0, 1'b0, P_MR, 1'b1, "ab_memread");
    do_reset(1);
    run_instr(OP_LW, 1'b0, 0, 0);
    chk("ab_restart_retire", 32'(ret_g), 32'd5);

    // Reduced instance: JALR disabled traps as illegal.
    sel = 1'b1;
    do_reset(2);
    cyc(OP_JALR, 1'b0, 1'b1, P_FD, 1'b1, "jalr_off_fetch");
    cyc(OP_JALR, 1'b0, 1'b0, P_D, 1'b1, "jalr_off_decode");
    ill_m = 1'b1;
    repeat (10) cyc(OP_JALR, rb(), rb(), P_TR, 1'b0, "jalr_off_trap");
    do_reset(1);
    run_instr(OP_I, 1'b0, 0, 0);

    // Fetch timeout after four unanswered cycles.
    do_reset(1);
    repeat (4) cyc(OP_I, rb(), 1'b0, P_F, 1'b1, "to_fetch");
    mf_m = 1'b1;
    repeat (3) cyc(OP_I, rb(), rb(), P_TR, 1'b0, "to_trap");
    // Ready on the fourth cycle still completes; same boundary for a load and a store.
    do_reset(1);
    run_instr(OP_I, 1'b0, 3, 0);
    run_instr(OP_LW, 1'b0, 3, 3);
    run_instr(OP_SW, 1'b0, 0, 3);
    chk("b_boundary_memwrite", 32'(nmw_g), 32'd4);

    // 4-bit instret wraps after 16 retirements.
    do_reset(1);
    repeat (16) run_instr(OP_I, rb(), 0, 0);
    @(posedge clk);
    #1;
    chk("instret_wrap", o_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
